// File: rtl/motor_pwm_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// motor_pwm_ctrl
// Speed/direction command front end for one motor channel. A signed speed
// command is taken over a valid/ready handshake and is held pending until the
// next PWM period boundary. At that boundary it is either applied directly or,
// if it reverses the direction, the bridge is first disabled for DEADTIME
// clocks before it restarts in the new direction.
//
// Parameters
//   DUTY_W    duty resolution in bits; PWM period is 2^DUTY_W clocks
//   DEADTIME  coast length in clocks on a direction reversal (1..65535)
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   cmd_valid  speed command valid
//   cmd_speed  signed speed, positive = forward, negative = reverse
//   cmd_ready  block can accept a command
//   pwm        PWM waveform to the direction selector
//   dir        direction, 1 = forward
//   en         bridge enable
// ---------------------------------------------------------------------------
module motor_pwm_ctrl #(
   parameter int DUTY_W   = 8,
   parameter int DEADTIME = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   input  logic signed [DUTY_W:0]   cmd_speed,
   output logic                     cmd_ready,
   output logic                     pwm,
   output logic                     dir,
   output logic                     en
);

   typedef enum logic [1:0] {IDLE, RUN, COAST} state_t;

   localparam logic [DUTY_W-1:0] CNT_ONE = {{(DUTY_W-1){1'b0}}, 1'b1};
   localparam logic [15:0]       DT_LOAD = 16'(DEADTIME - 1);

   state_t              state_reg, state_next;
   logic [DUTY_W-1:0]   cnt_reg;
   logic [DUTY_W-1:0]   duty_reg;
   logic                dir_reg;
   logic                pend_valid_reg;
   logic [DUTY_W-1:0]   pend_mag_reg;
   logic                pend_dir_reg;
   logic [15:0]         dt_cnt_reg;

   logic                boundary;
   logic                accept;
   logic                pend_act;
   logic                stop_req;
   logic                rev_req;
   logic                dt_done;
   logic                clear_pend;
   logic [DUTY_W:0]     mag_full;
   logic [DUTY_W-1:0]   cmd_mag;
   logic                cmd_dir;

   assign boundary = (cnt_reg == {DUTY_W{1'b1}});
   assign accept   = cmd_valid && cmd_ready;

   // |cmd_speed|; only the most negative code overflows DUTY_W bits and
   // is clamped to full scale.
   assign mag_full = cmd_speed[DUTY_W] ? $unsigned(-cmd_speed) : $unsigned(cmd_speed);
   assign cmd_mag  = mag_full[DUTY_W] ? {DUTY_W{1'b1}} : mag_full[DUTY_W-1:0];
   // A zero command keeps the present direction so it never triggers a coast.
   assign cmd_dir  = (cmd_speed == '0) ? dir_reg : !cmd_speed[DUTY_W];

   // Pending command is only evaluated at a boundary outside COAST.
   assign pend_act = boundary && pend_valid_reg && (state_reg != COAST);
   assign stop_req = (pend_mag_reg == '0);
   assign rev_req  = (pend_dir_reg != dir_reg);
   assign dt_done  = (state_reg == COAST) && (dt_cnt_reg == 16'd0);
   // A reversing command stays pending through COAST and is consumed at exit.
   assign clear_pend = (pend_act && (stop_req || !rev_req)) || dt_done;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (pend_act && !stop_req) begin
               state_next = rev_req ? COAST : RUN;
            end
         end
         RUN: begin
            if (pend_act) begin
               if (stop_req) begin
                  state_next = IDLE;
               end else if (rev_req) begin
                  state_next = COAST;
               end
            end
         end
         COAST: begin
            if (dt_done) begin
               state_next = RUN;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg        <= '0;
         duty_reg       <= '0;
         dir_reg        <= 1'b1;
         pend_valid_reg <= 1'b0;
         pend_mag_reg   <= '0;
         pend_dir_reg   <= 1'b1;
         dt_cnt_reg     <= '0;
      end else begin
         // Counter restarts at COAST exit so the new direction gets a full
         // first period.
         cnt_reg <= dt_done ? '0 : cnt_reg + CNT_ONE;

         if (state_reg != COAST && state_next == COAST) begin
            dt_cnt_reg <= DT_LOAD;
         end else if (state_reg == COAST && !dt_done) begin
            dt_cnt_reg <= dt_cnt_reg - 16'd1;
         end

         if (accept) begin
            pend_valid_reg <= 1'b1;
            pend_mag_reg   <= cmd_mag;
            pend_dir_reg   <= cmd_dir;
         end else if (clear_pend) begin
            pend_valid_reg <= 1'b0;
         end

         if (dt_done) begin
            duty_reg <= pend_mag_reg;
            dir_reg  <= pend_dir_reg;
         end else if (pend_act) begin
            duty_reg <= (stop_req || rev_req) ? '0 : pend_mag_reg;
         end
      end
   end

   // Output decode, registers only
   always_comb begin
      en        = (state_reg == RUN);
      pwm       = en && (cnt_reg < duty_reg);
      dir       = dir_reg;
      cmd_ready = !pend_valid_reg && (state_reg != COAST);
   end

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_motor_pwm_ctrl
// Drives speed commands and pushes the expected PWM periods and coast
// intervals onto a queue; a monitor measures each completed period (pwm high
// count, length, dir) and each reversal gap, pops the matching expectation
// and compares.
// ---------------------------------------------------------------------------
module tb_motor_pwm_ctrl;

   localparam int PERIOD = 256;
   localparam int DT     = 64;

   typedef struct {
      int kind;   // 0 = period, 1 = coast, 2 = nothing expected
      int a;      // period: pwm high clocks   coast: en-low clocks
      int b;      // period: period length     coast: dir during coast
      int c;      // period: dir               coast: dir after coast
   } rec_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic signed [8:0] cmd_speed = '0;
   logic              cmd_ready;
   logic              pwm;
   logic              dir;
   logic              en;

   int   n_checks = 0;
   int   n_fail   = 0;
   rec_t sb_q[$];

   // monitor state
   bit   m_prev_en  = 1'b0;
   bit   m_prev_pwm = 1'b0;
   bit   m_prev_dir = 1'b1;
   bit   m_in_per   = 1'b0;
   bit   m_per_dir  = 1'b1;
   bit   m_gap_dir  = 1'b1;
   int   m_high     = 0;
   int   m_low      = 0;
   int   m_gap_len  = 0;

   motor_pwm_ctrl #(.DUTY_W(8), .DEADTIME(DT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_speed (cmd_speed),
      .cmd_ready (cmd_ready),
      .pwm       (pwm),
      .dir       (dir),
      .en        (en)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic exp_period(input int high, input int d, input int n);
      rec_t r;
      r = '{kind: 0, a: high, b: PERIOD, c: d};
      repeat (n) sb_q.push_back(r);
   endtask

   task automatic exp_coast(input int old_dir, input int new_dir);
      rec_t r;
      r = '{kind: 1, a: DT, b: old_dir, c: new_dir};
      sb_q.push_back(r);
   endtask

   task automatic sb_compare(input int kind, input int a, input int b, input int c);
      rec_t e;
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else e = '{kind: 2, a: 0, b: 0, c: 0};
      if (kind == 0)
         $display("[%0t] period: high=%0d len=%0d dir=%0d", $time, a, b, c);
      else
         $display("[%0t] coast: len=%0d dir %0d->%0d", $time, a, b, c);
      check_eq("sb_kind", kind, e.kind);
      if (e.kind == kind) begin
         if (kind == 0) begin
            check_eq("per_high", a, e.a);
            check_eq("per_len", b, e.b);
            check_eq("per_dir", c, e.c);
         end else begin
            check_eq("coast_len", a, e.a);
            check_eq("coast_old_dir", b, e.b);
            check_eq("coast_new_dir", c, e.c);
         end
      end
   endtask

   // Caller sits at a negedge; returns at the negedge after acceptance.
   task automatic send(input logic signed [8:0] spd);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_speed = spd;
      while (!cmd_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_eq("send_ready", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      $display("[%0t] command %0d accepted", $time, spd);
   endtask

   task automatic wait_empty(input string tag);
      int n = 0;
      while (sb_q.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, sb_q.size(), 0);
   endtask

   // Output monitor: samples on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_in_per   = 1'b0;
            m_prev_en  = 1'b0;
            m_prev_pwm = 1'b0;
            m_gap_dir  = dir;
            m_prev_dir = dir;
            m_gap_len  = 0;
         end else begin
            if (en) begin
               if (!m_prev_en && (dir !== m_gap_dir))
                  sb_compare(1, m_gap_len, int'(m_prev_dir), int'(dir));
               if (pwm && (!m_prev_en || !m_prev_pwm)) begin
                  if (m_in_per) sb_compare(0, m_high, m_high + m_low, int'(m_per_dir));
                  m_in_per  = 1'b1;
                  m_high    = 1;
                  m_low     = 0;
                  m_per_dir = dir;
               end else if (m_in_per) begin
                  if (pwm) m_high++;
                  else m_low++;
               end
            end else begin
               if (m_prev_en) begin
                  if (m_in_per) sb_compare(0, m_high, m_high + m_low, int'(m_per_dir));
                  m_in_per  = 1'b0;
                  m_gap_dir = m_prev_dir;
                  m_gap_len = 1;
               end else begin
                  m_gap_len++;
               end
            end
            m_prev_en  = en;
            m_prev_pwm = pwm;
            m_prev_dir = dir;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      // Reset held with inputs toggling
      rst_n = 1'b0;
      repeat (6) begin
         @(negedge clk);
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_speed = 9'($urandom);
      end
      check_eq("rst_pwm", pwm, 0);
      check_eq("rst_en", en, 0);
      check_eq("rst_dir", dir, 1);
      check_eq("rst_ready", cmd_ready, 1);
      cmd_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;                       // counter reads 0 at this sample

      // Forward start: +64 accepted at cnt = 10
      repeat (10) @(negedge clk);
      exp_period(64, 1, 2);
      send(9'sd64);
      n = 0;
      while (!cmd_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_eq("fwd_ready_low", n, PERIOD - 11);
      check_eq("fwd_en", en, 1);
      check_eq("fwd_dir", dir, 1);
      check_eq("fwd_pwm_first", pwm, 1);
      wait_empty("fwd_done");

      // Reversal to -100
      exp_period(64, 1, 1);
      exp_coast(1, 0);
      exp_period(100, 0, 2);
      send(-9'sd100);
      wait_empty("rev_done");

      // Saturation with -256
      exp_period(100, 0, 1);
      exp_period(255, 0, 2);
      send(-9'sd256);
      wait_empty("sat_done");

      // Stop with 0
      exp_period(255, 0, 1);
      send(9'sd0);
      wait_empty("stop_done");
      check_eq("stop_en", en, 0);
      check_eq("stop_pwm", pwm, 0);
      check_eq("stop_dir", dir, 0);
      repeat (300) @(negedge clk);
      check_eq("idle_en", en, 0);
      check_eq("idle_ready", cmd_ready, 1);

      // Back-pressure: +30 held while the -20 command is pending
      exp_period(20, 0, 1);
      exp_coast(0, 1);
      exp_period(30, 1, 1);
      send(-9'sd20);
      cmd_valid = 1'b1;
      cmd_speed = 9'sd30;
      n = 0;
      while (!cmd_ready && n < 600) begin
         @(negedge clk);
         n++;
      end
      check_eq("bp_ready_rise", cmd_ready, 1);
      check_eq("bp_en_at_rise", en, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_eq("bp_accepted", cmd_ready, 0);
      wait_empty("bp_done");

      // Reverse to -50
      exp_period(30, 1, 1);
      exp_coast(1, 0);
      exp_period(50, 0, 1);
      send(-9'sd50);
      wait_empty("rev2_done");

      // Reversal to +40 interrupted by reset mid-coast
      exp_period(50, 0, 1);
      send(9'sd40);
      wait_empty("coast_entry");
      repeat (10) @(negedge clk);
      check_eq("coast_ready", cmd_ready, 0);
      check_eq("coast_dir", dir, 0);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_en", en, 0);
      check_eq("mid_rst_pwm", pwm, 0);
      check_eq("mid_rst_dir", dir, 1);
      check_eq("mid_rst_ready", cmd_ready, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (400) @(negedge clk);
      check_eq("post_rst_en", en, 0);
      check_eq("post_rst_dir", dir, 1);
      check_eq("post_rst_ready", cmd_ready, 1);
      check_eq("sb_leftover", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
